// File: rtl/chess_lmg_pkg.sv
// chess_lmg_pkg: LMG word geometry, move type and unpacker states shared by the LMG and control blocks
package chess_lmg_pkg;
    localparam int SLOTS = 8;
    localparam int MOVE_W = 18;
    localparam int SLOT_W = MOVE_W + 1;
    localparam int WORD_W = SLOTS * SLOT_W;

    typedef logic [MOVE_W-1:0] move_t;

    typedef enum logic [2:0] {U_IDLE, U_WAIT, U_FETCH, U_CAPT, U_EMIT, U_DONE} unpackState_t;

    function automatic int slotOffset(input int i, input int slotW);
        return i * slotW;
    endfunction
endpackage

// File: rtl/lmg_move_unpacker_lsb_pick.sv
// lsb_pick: lowest set bit of a mask as one-hot, binary index and any-set flag
module lsb_pick #(
    parameter int N = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     mask,
    output logic [N-1:0]     oneHot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    assign oneHot = mask & (-mask);
    assign any = |mask;
    // Scan from the top so the lowest set bit is written last
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) if (mask[i]) idx = IDX_W'(i);
    end
endmodule

// File: rtl/lmg_move_unpacker.sv
// lmg_move_unpacker: drains the LMG FIFO after done and streams valid moves one per cycle.
// Build option UNPACK_TERMINATOR_EN: an all-invalid word ends the list instead of being skipped.
module lmg_move_unpacker #(
    parameter int SLOTS = chess_lmg_pkg::SLOTS,
    parameter int MOVE_W = chess_lmg_pkg::MOVE_W,
    parameter int CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      lmg_done,
    input  logic                      lmg_fifo_empty,
    input  logic [SLOTS*(MOVE_W+1)-1:0] lmg_fifo_out,
    output logic                      lmg_rden,
    output logic                      move_valid,
    input  logic                      move_ready,
    output logic [MOVE_W-1:0]         move_data,
    output logic [CNT_W-1:0]          move_index,
    output logic [CNT_W-1:0]          move_count,
    output logic                      list_done,
    output logic                      overflow
);
    import chess_lmg_pkg::*;

    localparam int SW = MOVE_W + 1;
    localparam int IW = $clog2(SLOTS);
    localparam logic [CNT_W-1:0] CMAX = '1;

    unpackState_t state;
    logic [SLOTS*SW-1:0] word, srcWord;
    logic [SLOTS-1:0] mask, curBit, validSlots, nextMask, pickHot;
    logic [IW-1:0] pickIdx;
    logic pickAny, advance, endList;
    logic [CNT_W-1:0] countAfter;
    logic [MOVE_W-1:0] pickData;

    // Slot validity of the word arriving from the FIFO
    always_comb begin
        validSlots = '0;
        for (int i = 0; i < SLOTS; i++) validSlots[i] = ~lmg_fifo_out[slotOffset(i, SW) + MOVE_W];
    end

    // A slot retires on handshake, or silently once the counter has saturated
    assign advance = (state == U_EMIT) && (!move_valid || move_ready);
    assign srcWord = (state == U_CAPT) ? lmg_fifo_out : word;
    assign nextMask = (state == U_CAPT) ? validSlots : (mask & ~curBit);
    assign countAfter = (advance && move_valid) ? move_count + CNT_W'(1) : move_count;
    assign pickData = srcWord[slotOffset(int'(pickIdx), SW) +: MOVE_W];

`ifdef UNPACK_TERMINATOR_EN
    assign endList = lmg_fifo_empty || (state == U_CAPT);
`else
    assign endList = lmg_fifo_empty;
`endif

    lsb_pick #(.N(SLOTS), .IDX_W(IW)) u_pick (
        .mask(nextMask),
        .oneHot(pickHot),
        .idx(pickIdx),
        .any(pickAny)
    );

    // Drain FSM; every output is registered and the next move is preloaded as the current one retires
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= U_IDLE;
            word <= '0;
            mask <= '0;
            curBit <= '0;
            lmg_rden <= 1'b0;
            move_valid <= 1'b0;
            move_data <= '0;
            move_index <= '0;
            move_count <= '0;
            list_done <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                U_IDLE, U_DONE: if (start) begin
                    state <= U_WAIT;
                    move_count <= '0;
                    move_index <= '0;
                    overflow <= 1'b0;
                    list_done <= 1'b0;
                end
                U_WAIT: if (lmg_done) begin
                    state <= lmg_fifo_empty ? U_DONE : U_FETCH;
                    lmg_rden <= !lmg_fifo_empty;
                    list_done <= lmg_fifo_empty;
                end
                U_FETCH: begin
                    lmg_rden <= 1'b0;
                    state <= U_CAPT;
                end
                U_CAPT, U_EMIT: if (state == U_CAPT || advance) begin
                    word <= srcWord;
                    mask <= nextMask;
                    curBit <= pickHot;
                    move_data <= pickData;
                    move_index <= countAfter;
                    move_count <= countAfter;
                    move_valid <= pickAny && (countAfter != CMAX);
                    if (advance && !move_valid) overflow <= 1'b1;
                    state <= pickAny ? U_EMIT : (endList ? U_DONE : U_FETCH);
                    lmg_rden <= !pickAny && !endList;
                    list_done <= !pickAny && endList;
                end
                default: state <= U_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lmg_move_unpacker.sv
// tb_lmg_move_unpacker: directed checks of the move unpacker with a 4-bit counter and a simple FIFO model
module tb_lmg_move_unpacker;
    import chess_lmg_pkg::*;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset, start, lmg_done, lmg_fifo_empty, lmg_rden;
    logic move_valid, move_ready, list_done, overflow;
    logic [WORD_W-1:0] lmg_fifo_out = '0;
    move_t move_data;
    logic [CW-1:0] move_index, move_count;

    logic [WORD_W-1:0] fifoMem [64];
    int wrPtr = 0;
    int rdPtr = 0;
    int nAssert = 0;
    int nFail = 0;
    move_t gotData [64];
    logic [CW-1:0] gotIdx [64];
    int gotCyc [64];
    move_t expData [16];
    int nGot, rdenSeen;
    logic [WORD_W-1:0] w;

    lmg_move_unpacker #(.SLOTS(SLOTS), .MOVE_W(MOVE_W), .CNT_W(CW)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .lmg_done(lmg_done),
        .lmg_fifo_empty(lmg_fifo_empty),
        .lmg_fifo_out(lmg_fifo_out),
        .lmg_rden(lmg_rden),
        .move_valid(move_valid),
        .move_ready(move_ready),
        .move_data(move_data),
        .move_index(move_index),
        .move_count(move_count),
        .list_done(list_done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    assign lmg_fifo_empty = (rdPtr == wrPtr);

    // FIFO read data appears the cycle after the read strobe
    always @(posedge clk) begin
        if (lmg_rden) begin
            lmg_fifo_out <= fifoMem[rdPtr % 64];
            rdPtr <= rdPtr + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] allInv();
        logic [WORD_W-1:0] r;
        r = '0;
        for (int i = 0; i < SLOTS; i++) r[i*SLOT_W +: SLOT_W] = {1'b1, {MOVE_W{1'b1}}};
        return r;
    endfunction

    function automatic logic [WORD_W-1:0] putSlot(input logic [WORD_W-1:0] wi, input int i, input move_t m);
        logic [WORD_W-1:0] r;
        r = wi;
        r[i*SLOT_W +: SLOT_W] = {1'b0, m};
        return r;
    endfunction

    task automatic push(input logic [WORD_W-1:0] wd);
        fifoMem[wrPtr % 64] = wd;
        wrPtr++;
    endtask

    task automatic flush();
        wrPtr = rdPtr;
    endtask

    task automatic pulseStart();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic checkIdle(input string tag);
        check({tag, "_rden"}, 64'(lmg_rden), 64'd0);
        check({tag, "_valid"}, 64'(move_valid), 64'd0);
        check({tag, "_data"}, 64'(move_data), 64'd0);
        check({tag, "_index"}, 64'(move_index), 64'd0);
        check({tag, "_count"}, 64'(move_count), 64'd0);
        check({tag, "_list_done"}, 64'(list_done), 64'd0);
        check({tag, "_overflow"}, 64'(overflow), 64'd0);
    endtask

    // Runs until list_done, recording handshakes, read strobes and stall stability
    task automatic drain(input bit toggle, input int budget);
        logic stall;
        move_t held;
        stall = 1'b0;
        held = '0;
        nGot = 0;
        rdenSeen = 0;
        for (int c = 0; c < budget && !list_done; c++) begin
            @(negedge clk);
            move_ready = toggle ? ~move_ready : 1'b1;
            #1;
            if (stall) begin
                check("stall_valid", 64'(move_valid), 64'd1);
                check("stall_data", 64'(move_data), 64'(held));
            end
            if (move_valid && move_ready && nGot < 64) begin
                gotData[nGot] = move_data;
                gotIdx[nGot] = move_index;
                gotCyc[nGot] = c;
                nGot++;
            end
            if (lmg_rden) rdenSeen++;
            stall = move_valid && !move_ready;
            held = move_data;
        end
        check("list_done_reached", 64'(list_done), 64'd1);
        move_ready = 1'b1;
    endtask

    task automatic checkMoves(input string tag, input int n);
        check({tag, "_moves"}, 64'(nGot), 64'(n));
        for (int i = 0; i < n && i < nGot; i++) begin
            check({tag, "_data"}, 64'(gotData[i]), 64'(expData[i]));
            check({tag, "_index"}, 64'(gotIdx[i]), 64'(i));
        end
    endtask

    initial begin
        int r;
        reset = 1'b1;
        start = 1'b0;
        lmg_done = 1'b0;
        move_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1 checkIdle("reset");

        // Single word, slots 0,3,7 valid; drain held off until lmg_done
        flush();
        w = allInv();
        w = putSlot(w, 0, 18'h0000A);
        w = putSlot(w, 3, 18'h000B3);
        w = putSlot(w, 7, 18'h003FF);
        push(w);
        pulseStart();
        repeat (3) @(negedge clk);
        #1;
        check("t1_wait_rden", 64'(lmg_rden), 64'd0);
        check("t1_wait_valid", 64'(move_valid), 64'd0);
        lmg_done = 1'b1;
        drain(1'b0, 60);
        expData[0] = 18'h0000A;
        expData[1] = 18'h000B3;
        expData[2] = 18'h003FF;
        checkMoves("t1", 3);
        check("t1_count", 64'(move_count), 64'd3);
        check("t1_overflow", 64'(overflow), 64'd0);
        check("t1_rden", 64'(rdenSeen), 64'd1);
        check("t1_b2b_01", 64'(gotCyc[1] - gotCyc[0]), 64'd1);
        check("t1_b2b_12", 64'(gotCyc[2] - gotCyc[1]), 64'd1);

        // Same word with ready toggling every cycle
        flush();
        push(w);
        pulseStart();
        drain(1'b1, 60);
        checkMoves("t2", 3);
        check("t2_count", 64'(move_count), 64'd3);

        // Two words: 8 valid then slots 2,5
        flush();
        w = allInv();
        for (int i = 0; i < 8; i++) w = putSlot(w, i, move_t'(18'h100 + i));
        push(w);
        w = allInv();
        w = putSlot(w, 2, 18'h00202);
        w = putSlot(w, 5, 18'h00205);
        push(w);
        pulseStart();
        drain(1'b0, 80);
        for (int i = 0; i < 8; i++) expData[i] = move_t'(18'h100 + i);
        expData[8] = 18'h00202;
        expData[9] = 18'h00205;
        checkMoves("t3", 10);
        check("t3_count", 64'(move_count), 64'd10);
        check("t3_rden", 64'(rdenSeen), 64'd2);
        check("t3_b2b_67", 64'(gotCyc[7] - gotCyc[6]), 64'd1);
        check("t3_gap_78", 64'(gotCyc[8] - gotCyc[7]), 64'd3);

        // All-invalid word in the middle of the list
        flush();
        w = allInv();
        w = putSlot(w, 1, 18'h00011);
        w = putSlot(w, 6, 18'h00016);
        push(w);
        push(allInv());
        w = allInv();
        w = putSlot(w, 0, 18'h00030);
        push(w);
        pulseStart();
        drain(1'b0, 80);
        expData[0] = 18'h00011;
        expData[1] = 18'h00016;
        expData[2] = 18'h00030;
`ifdef UNPACK_TERMINATOR_EN
        checkMoves("t4", 2);
        check("t4_count", 64'(move_count), 64'd2);
        check("t4_rden", 64'(rdenSeen), 64'd2);
`else
        checkMoves("t4", 3);
        check("t4_count", 64'(move_count), 64'd3);
        check("t4_rden", 64'(rdenSeen), 64'd3);
`endif

        // 20 valid moves into a 4-bit counter
        flush();
        for (int k = 0; k < 3; k++) begin
            w = allInv();
            for (int i = 0; i < (k == 2 ? 4 : 8); i++) w = putSlot(w, i, move_t'(18'h500 + k * 8 + i));
            push(w);
        end
        pulseStart();
        drain(1'b0, 120);
        for (int i = 0; i < 15; i++) expData[i] = move_t'(18'h500 + i);
        checkMoves("t5", 15);
        check("t5_count", 64'(move_count), 64'd15);
        check("t5_overflow", 64'(overflow), 64'd1);
        check("t5_rden", 64'(rdenSeen), 64'd3);

        // Reset in the middle of EMIT with the consumer stalled
        flush();
        w = allInv();
        for (int i = 0; i < 8; i++) w = putSlot(w, i, move_t'(18'h100 + i));
        push(w);
        push(w);
        pulseStart();
        move_ready = 1'b0;
        for (int c = 0; c < 20 && !move_valid; c++) @(negedge clk);
        #1 check("t6_in_emit", 64'(move_valid), 64'd1);
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        #1 checkIdle("t6_reset");
        move_ready = 1'b1;
        r = 0;
        repeat (4) begin
            @(negedge clk);
            if (lmg_rden || move_valid) r++;
        end
        check("t6_idle_no_activity", 64'(r), 64'd0);

        // Clean drain after reset
        flush();
        w = allInv();
        w = putSlot(w, 0, 18'h0000A);
        w = putSlot(w, 3, 18'h000B3);
        w = putSlot(w, 7, 18'h003FF);
        push(w);
        pulseStart();
        drain(1'b0, 60);
        expData[0] = 18'h0000A;
        expData[1] = 18'h000B3;
        expData[2] = 18'h003FF;
        checkMoves("t6_rerun", 3);
        check("t6_rerun_count", 64'(move_count), 64'd3);

        // Done with an empty FIFO
        flush();
        pulseStart();
        drain(1'b0, 20);
        check("t6_empty_moves", 64'(nGot), 64'd0);
        check("t6_empty_count", 64'(move_count), 64'd0);
        check("t6_empty_rden", 64'(rdenSeen), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
